// File: rtl/sobel_pkg.sv
// Shared mode encoding, width helpers and saturation for the Sobel stream.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_BIN = 2'd0,
    MODE_MAG = 2'd1,
    MODE_GX  = 2'd2,
    MODE_GY  = 2'd3
  } mode_e;

  localparam int GRAD_EXTRA = 4;
  localparam int SUM_EXTRA  = 4;

  function automatic int grad_w(input int pix_w);
    return pix_w + GRAD_EXTRA;
  endfunction

  function automatic int sum_w(input int pix_w);
    return pix_w + SUM_EXTRA;
  endfunction

  // Clamp an unsigned value to w bits of all-ones.
  function automatic logic [31:0] saturate(input logic [31:0] v, input int unsigned w);
    logic [31:0] mx;
    mx = (32'd1 << w) - 32'd1;
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line buffer: read-before-write, registered read data.
module sobel_line_buffer #(
  parameter int PIX_W    = 8,
  parameter int MAX_LINE = 1024
) (
  input  logic                        clock,
  input  logic                        en,
  input  logic [$clog2(MAX_LINE)-1:0] addr,
  input  logic [PIX_W-1:0]            wr_data,
  output logic [PIX_W-1:0]            rd_data
);

  logic [PIX_W-1:0] mem [MAX_LINE];

  always_ff @(posedge clock) begin
    if (en) begin
      rd_data   <= mem[addr];
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel |Gx|+|Gy| with runtime line length, threshold and output mode.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int MAX_LINE = 1024,
  parameter int LL_W     = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [LL_W-1:0]  line_len,
  input  logic [PIX_W+2:0] thresh,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sol,
  input  logic             pix_sof,
  output logic [PIX_W-1:0] edge_out,
  output logic             edge_valid,
  output logic             edge_sol,
  output logic             edge_sof
);

  localparam int GW     = grad_w(PIX_W);
  localparam int SW     = sum_w(PIX_W);
  localparam int AW     = $clog2(MAX_LINE);
  localparam int STAGES = 4;

  // ---- position counters ----
  logic [LL_W-1:0] col_q, cur_col;
  logic [1:0]      row_q, cur_row;
  logic            fresh, sof_eff, sol_eff;

  // After reset the next valid pixel restarts the frame even without sof.
  always_comb begin
    sof_eff = pix_sof | fresh;
    sol_eff = sof_eff | pix_sol | (col_q == line_len);
    cur_col = sol_eff ? '0 : col_q + LL_W'(1);
    cur_row = row_q;
    if (sof_eff)                        cur_row = 2'd0;
    else if (sol_eff && row_q != 2'd2)  cur_row = row_q + 2'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      fresh <= 1'b1;
    end else if (pix_valid) begin
      col_q <= cur_col;
      row_q <= cur_row;
      fresh <= 1'b0;
    end
  end

  // ---- tag pipeline: stage 0 is the input sample, stage STAGES the output ----
  logic [STAGES:0] vld_pipe, sol_pipe, sof_pipe, msk_pipe;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
      sol_pipe <= '0;
      sof_pipe <= '0;
      msk_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], pix_valid};
      sol_pipe <= {sol_pipe[STAGES-1:0], pix_valid & sol_eff};
      sof_pipe <= {sof_pipe[STAGES-1:0], pix_valid & pix_sof};
      msk_pipe <= {msk_pipe[STAGES-1:0], (cur_row < 2'd2) || (cur_col < LL_W'(2))};
    end
  end

  assign edge_valid = vld_pipe[STAGES];
  assign edge_sol   = sol_pipe[STAGES];
  assign edge_sof   = sof_pipe[STAGES];

  // ---- line buffers ----
  logic [PIX_W-1:0] p_d, a_rd, b_rd;
  logic [AW-1:0]    col_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      p_d   <= '0;
      col_d <= '0;
    end else if (pix_valid) begin
      p_d   <= pix_in;
      col_d <= cur_col[AW-1:0];
    end
  end

  // B trails A by one clock so it can store A's registered read (row r-1) at the same column.
  sobel_line_buffer #(.PIX_W(PIX_W), .MAX_LINE(MAX_LINE)) u_lb_a (
    .clock   (clock),
    .en      (pix_valid),
    .addr    (cur_col[AW-1:0]),
    .wr_data (pix_in),
    .rd_data (a_rd)
  );

  sobel_line_buffer #(.PIX_W(PIX_W), .MAX_LINE(MAX_LINE)) u_lb_b (
    .clock   (clock),
    .en      (vld_pipe[0]),
    .addr    (col_d),
    .wr_data (a_rd),
    .rd_data (b_rd)
  );

  // ---- 3x3 window: [0]=top, [1]=mid, [2]=bottom ----
  logic [2:0][PIX_W-1:0] win_l, win_m, win_r;
  logic [PIX_W-1:0]      mid_r, bot_r;

  assign win_r = {bot_r, mid_r, b_rd};

  always_ff @(posedge clock) begin
    if (reset) begin
      win_l <= '0;
      win_m <= '0;
      mid_r <= '0;
      bot_r <= '0;
    end else if (vld_pipe[0]) begin
      win_l <= win_m;
      win_m <= win_r;
      mid_r <= a_rd;
      bot_r <= p_d;
    end
  end

  // ---- gradients ----
  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return signed'(GW'(p));
  endfunction

  logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;

  always_comb begin
    gx_c = (ext(win_r[0]) - ext(win_l[0]))
         + ((ext(win_r[1]) - ext(win_l[1])) <<< 1)
         + (ext(win_r[2]) - ext(win_l[2]));
    gy_c = (ext(win_l[0]) - ext(win_l[2]))
         + ((ext(win_m[0]) - ext(win_m[2])) <<< 1)
         + (ext(win_r[0]) - ext(win_r[2]));
  end

  logic [GW-2:0] agx_q, agy_q;

  always_ff @(posedge clock) begin
    gx_q  <= gx_c;
    gy_q  <= gy_c;
    agx_q <= (GW-1)'($unsigned(gx_q[GW-1] ? -gx_q : gx_q));
    agy_q <= (GW-1)'($unsigned(gy_q[GW-1] ? -gy_q : gy_q));
  end

  // ---- sum and output select ----
  logic [SW-1:0]    sum_c;
  logic [PIX_W-1:0] res_c;

  always_comb begin
    sum_c = SW'(agx_q) + SW'(agy_q);
    res_c = '0;
    unique case (mode_e'(mode))
      MODE_BIN: res_c = (sum_c > SW'(thresh)) ? '1 : '0;
      MODE_MAG: res_c = PIX_W'(saturate(32'(sum_c), PIX_W));
      MODE_GX:  res_c = PIX_W'(saturate(32'(agx_q), PIX_W));
      MODE_GY:  res_c = PIX_W'(saturate(32'(agy_q), PIX_W));
      default:  res_c = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                                    edge_out <= '0;
    else if (!vld_pipe[STAGES-1] || msk_pipe[STAGES-1]) edge_out <= '0;
    else                                          edge_out <= res_c;
  end

endmodule
